// File: rtl/noc_injector.sv
`default_nettype none
// ============================================================================
//  Module      : noc_injector
//  Description : Network-interface injector for a router's local write port.
//                Accepts {dest, payload} requests from a processing element
//                over valid/ready, packs them into WIDTH-bit flits, buffers
//                them in a DEPTH-entry FIFO and drains them into the router
//                local port, throttled by the router's full/almost_full.
//
//  Ports       : clk              rising-edge clock
//                reset            asynchronous, active-low reset
//                pe_valid/ready   PE request handshake
//                pe_dest          destination router id (0..3)
//                pe_payload       WIDTH-2 payload bits
//                noc_write        one-cycle write strobe per flit
//                noc_data         flit {dest, payload}
//                noc_full         router local FIFO full
//                noc_almost_full  router local FIFO almost full (stop signal)
//                occupancy        flits currently buffered (0..DEPTH)
//                sent_count       [NOC_INJ_STATS_EN] flits injected, saturating
//                stall_cycles     [NOC_INJ_STATS_EN] cycles spent in STALL
//
//  Options     : define NOC_INJ_STATS_EN to add the statistics counters and a
//                simulation-only trace line per injected flit.
//
//  Revision    : 1.0  initial release
// ============================================================================
module noc_injector #(
    parameter int         WIDTH     = 16,
    parameter int         DEPTH     = 8,
    parameter int         ADDWIDTH  = 3,
    parameter logic [1:0] ROUTER_ID = 2'b00
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                pe_valid,
    output logic                pe_ready,
    input  logic [1:0]          pe_dest,
    input  logic [WIDTH-3:0]    pe_payload,
    output logic                noc_write,
    output logic [WIDTH-1:0]    noc_data,
    input  logic                noc_full,
    input  logic                noc_almost_full,
`ifdef NOC_INJ_STATS_EN
    output logic [15:0]         sent_count,
    output logic [15:0]         stall_cycles,
`endif
    output logic [ADDWIDTH:0]   occupancy
);

    localparam logic [1:0]      c_IDLE  = 2'd0;
    localparam logic [1:0]      c_SEND  = 2'd1;
    localparam logic [1:0]      c_STALL = 2'd2;

    localparam logic [ADDWIDTH:0] c_FULL_COUNT = (ADDWIDTH+1)'(DEPTH);
    localparam logic [ADDWIDTH:0] c_ONE_COUNT  = (ADDWIDTH+1)'(1);

    logic [1:0]          r_state;
    logic [ADDWIDTH-1:0] r_wrPtr;
    logic [ADDWIDTH-1:0] r_rdPtr;
    logic [ADDWIDTH:0]   r_count;
    logic                r_nocWrite;
    logic [WIDTH-1:0]    r_nocData;
    logic [WIDTH-1:0]    r_mem [DEPTH];

    logic                w_blocked;
    logic                w_push;
    logic                w_pop;

    // almost_full is treated as a hard stop so that the strobe registered on
    // the sampling edge is the only flit that can still reach a filling router.
    assign w_blocked = noc_full || noc_almost_full;

    // pe_ready depends on registered occupancy only; no path from noc_* inputs.
    assign pe_ready  = (r_count != c_FULL_COUNT);
    assign w_push    = pe_valid && pe_ready;
    assign w_pop     = (r_state == c_SEND) && (r_count != '0) && !w_blocked;

    assign noc_write = r_nocWrite;
    assign noc_data  = r_nocData;
    assign occupancy = r_count;

    // Flit storage: no reset needed, pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {pe_dest, pe_payload};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= c_IDLE;
            r_wrPtr    <= '0;
            r_rdPtr    <= '0;
            r_count    <= '0;
            r_nocWrite <= 1'b0;
            r_nocData  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            // The strobe is a one-cycle pulse; data holds between pulses.
            r_nocWrite <= w_pop;
            if (w_pop) begin
                r_nocData <= r_mem[r_rdPtr];
            end

            case (r_state)
                c_IDLE: begin
                    if (r_count != '0) begin
                        r_state <= c_SEND;
                    end
                end
                c_SEND: begin
                    if (w_blocked) begin
                        r_state <= c_STALL;
                    end else if (w_pop && (r_count == c_ONE_COUNT) && !w_push) begin
                        r_state <= c_IDLE;
                    end
                end
                c_STALL: begin
                    if (!w_blocked) begin
                        r_state <= c_SEND;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef NOC_INJ_STATS_EN
    logic [15:0] r_sentCount;
    logic [15:0] r_stallCycles;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sentCount   <= '0;
            r_stallCycles <= '0;
        end else begin
            if (r_nocWrite && (r_sentCount != 16'hFFFF)) begin
                r_sentCount <= r_sentCount + 16'd1;
            end
            if ((r_state == c_STALL) && (r_stallCycles != 16'hFFFF)) begin
                r_stallCycles <= r_stallCycles + 16'd1;
            end
        end
    end

    assign sent_count   = r_sentCount;
    assign stall_cycles = r_stallCycles;

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (reset && w_pop) begin
            $display("noc_injector[%0d]: dest=%0d payload=%0h",
                     ROUTER_ID, r_mem[r_rdPtr][WIDTH-1:WIDTH-2], r_mem[r_rdPtr][WIDTH-3:0]);
        end
    end
`endif
`else
    // ROUTER_ID only matters to the statistics trace.
    logic w_unusedRouterId;
    assign w_unusedRouterId = ^ROUTER_ID;
`endif

endmodule
`default_nettype wire
